// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg -- shared definitions for the ROM download controller.
//   dl_state_e    : controller states (IDLE, LOAD, SETTLE, RUN)
//   ROM_SIZE_DEF  : byte count of a complete image
//   PROG_BASE     : program ROM region base ('h0000-'h3FFF)
//   VEC_BASE      : vector ROM region base ('h4000-'h4FFF)
//   BYTE_CNT_W    : width of the accepted-byte counter
package rom_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } dl_state_e;

    localparam int          ROM_SIZE_DEF = 'h5000;
    localparam logic [24:0] PROG_BASE    = 25'h0000;
    localparam logic [24:0] VEC_BASE     = 25'h4000;
    localparam int          BYTE_CNT_W   = 17;

endpackage

// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl -- sequences a ROM image download into the core and holds the
// core in reset until the image has landed and a settle period has elapsed.
//
// Parameters
//   ROM_SIZE       byte count of a complete image
//   SETTLE_CYCLES  cycles the core stays in reset after the download ends
// Ports
//   clk_i           in   sole clock, rising edge
//   btnCpuReset     in   synchronous active-low reset
//   ioctl_download  in   high for the whole transfer window
//   ioctl_wr        in   one-cycle byte strobe
//   ioctl_addr      in   byte address [24:0]
//   ioctl_dout      in   byte data [7:0]
//   dl_addr         out  registered address for the core's ROM ports
//   dl_data         out  registered data
//   dl_wr           out  registered, qualified write strobe
//   core_reset_n    out  core reset, high only in RUN
//   load_done       out  RUN reached after a clean load
//   load_error      out  sticky: wrong byte count or out-of-range write
//   checksum        out  modulo-2^16 sum of accepted bytes
// Build option
//   ROM_DL_CHECKSUM_EN  when defined, checksum accumulates accepted bytes;
//                       otherwise checksum is tied to zero.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter int ROM_SIZE      = ROM_SIZE_DEF,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        btnCpuReset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic        core_reset_n,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] checksum
);

    localparam int                    SW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [24:0]           ROM_END  = 25'(ROM_SIZE);
    localparam logic [BYTE_CNT_W-1:0] ROM_CNT  = BYTE_CNT_W'(ROM_SIZE);

    dl_state_e             state, state_nxt;
    logic                  dl_prev;
    logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_inc;
    logic [SW-1:0]         settle_cnt;

    logic rise, fall, load_entry, settle_entry, in_range, accept, oor;

    assign rise         = ioctl_download & ~dl_prev;
    assign fall         = ~ioctl_download & dl_prev;
    assign load_entry   = (state == ST_IDLE || state == ST_RUN) && rise;
    // The falling-edge cycle itself is still LOAD, so a byte arriving with
    // the edge is accepted and counted before the size check below.
    assign settle_entry = (state == ST_LOAD) && fall;
    assign in_range     = ioctl_addr < ROM_END;
    assign accept       = (state == ST_LOAD) && ioctl_wr && in_range;
    assign oor          = (state == ST_LOAD) && ioctl_wr && !in_range;
    assign byte_cnt_inc = (accept && byte_cnt != '1) ? byte_cnt + 1'b1 : byte_cnt;

    assign core_reset_n = (state == ST_RUN);
    assign load_done    = (state == ST_RUN) && !load_error;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (rise) state_nxt = ST_LOAD;
            ST_LOAD:   if (fall) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_RUN;
            ST_RUN:    if (rise) state_nxt = ST_LOAD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!btnCpuReset) begin
            state      <= ST_IDLE;
            // Track the live level during reset so a download already high
            // at release is not mistaken for a fresh rising edge.
            dl_prev    <= ioctl_download;
            dl_wr      <= 1'b0;
            dl_addr    <= '0;
            dl_data    <= '0;
            load_error <= 1'b0;
            byte_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            state   <= state_nxt;
            dl_prev <= ioctl_download;
            dl_wr   <= accept;
            if (accept) begin
                dl_addr <= ioctl_addr;
                dl_data <= ioctl_dout;
            end

            if (load_entry) byte_cnt <= '0;
            else            byte_cnt <= byte_cnt_inc;

            if (load_entry)
                load_error <= 1'b0;
            else if (oor || (settle_entry && byte_cnt_inc != ROM_CNT))
                load_error <= 1'b1;

            if (settle_entry)            settle_cnt <= '0;
            else if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk_i) begin
        if (!btnCpuReset)  sum <= '0;
        else if (load_entry) sum <= '0;
        else if (accept)   sum <= sum + {8'h00, ioctl_dout};
    end

    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// tb_rom_dl_ctrl -- self-checking bench for rom_dl_ctrl. Expected ROM writes
// are queued when driven and matched (address, data, arrival cycle) when the
// DUT strobes dl_wr. Status outputs are checked directly against a small
// model. Honours ROM_DL_CHECKSUM_EN for the checksum expectation.
module tb_rom_dl_ctrl;

    localparam int ROM_SIZE = 'h5000;
    localparam int SETTLE   = 1024;

    logic        clk_i = 1'b0;
    logic        btnCpuReset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic        core_reset_n;
    logic        load_done;
    logic        load_error;
    logic [15:0] checksum;

    rom_dl_ctrl #(.ROM_SIZE(ROM_SIZE), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_i          (clk_i),
        .btnCpuReset    (btnCpuReset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_wr          (dl_wr),
        .core_reset_n   (core_reset_n),
        .load_done      (load_done),
        .load_error     (load_error),
        .checksum       (checksum)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [24:0] a;
        logic [7:0]  d;
        int          c;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          in_load = 0;
    logic [15:0] m_sum = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_sum();
`ifdef ROM_DL_CHECKSUM_EN
        return m_sum;
`else
        return 16'h0000;
`endif
    endfunction

    // Scoreboard consumer: every dl_wr must match the oldest queued write
    // and arrive exactly one cycle after its ioctl_wr cycle.
    always @(negedge clk_i) begin
        if (btnCpuReset === 1'b1 && dl_wr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("dl_wr_unexpected", 32'(dl_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dl_addr", 32'(dl_addr), 32'(e.a));
                chk("dl_data", 32'(dl_data), 32'(e.d));
                chk("dl_wr_latency", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (in_load && a < 25'(ROM_SIZE)) begin
            sb.push_back('{a: a, d: d, c: cyc + 1});
            m_sum = m_sum + {8'h00, d};
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
        in_load = 1;
        m_sum   = '0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (core_reset_n !== 1'b1 && n < SETTLE + 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(SETTLE));
    endtask

    initial begin
        btnCpuReset    = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) tick();

        chk("rst_core_reset_n", 32'(core_reset_n), 0);
        chk("rst_load_done", 32'(load_done), 0);
        chk("rst_load_error", 32'(load_error), 0);
        chk("rst_checksum", 32'(checksum), 0);
        chk("rst_dl_wr", 32'(dl_wr), 0);
        chk("rst_dl_addr", 32'(dl_addr), 0);
        chk("rst_dl_data", 32'(dl_data), 0);

        btnCpuReset = 1'b1;
        repeat (2) tick();
        chk("idle_core_reset_n", 32'(core_reset_n), 0);

        // Full image of 'h01 bytes.
        start_dl();
        chk("load_core_reset_n", 32'(core_reset_n), 0);
        for (int i = 0; i < ROM_SIZE; i++) wr_byte(25'(i), 8'h01);
        ioctl_download = 1'b0;
        tick();
        in_load = 0;
        chk("full_load_error", 32'(load_error), 0);
        chk("full_checksum", 32'(checksum), 32'(exp_sum()));
        chk("settle_core_reset_n", 32'(core_reset_n), 0);
        wait_run("full_settle_cycles");
        chk("full_core_reset_n", 32'(core_reset_n), 1);
        chk("full_load_done", 32'(load_done), 1);

        // Writes in RUN are ignored, including out-of-range ones.
        wr_byte(25'h10, 8'h55);
        wr_byte(25'h6000, 8'h66);
        tick();
        chk("run_wr_load_error", 32'(load_error), 0);
        chk("run_wr_load_done", 32'(load_done), 1);
        chk("run_wr_checksum", 32'(checksum), 32'(exp_sum()));

        // Reload from RUN with one byte short of a full image.
        ioctl_download = 1'b1;
        chk("pre_reload_core_reset_n", 32'(core_reset_n), 1);
        tick();
        in_load = 1;
        m_sum   = '0;
        chk("reload_core_reset_n", 32'(core_reset_n), 0);
        chk("reload_load_done", 32'(load_done), 0);
        chk("reload_checksum", 32'(checksum), 0);
        for (int i = 0; i < ROM_SIZE - 1; i++) wr_byte(25'(i), 8'($urandom_range(0, 255)));
        ioctl_download = 1'b0;
        tick();
        in_load = 0;
        chk("short_load_error", 32'(load_error), 1);
        chk("short_checksum", 32'(checksum), 32'(exp_sum()));
        wait_run("short_settle_cycles");
        chk("short_core_reset_n", 32'(core_reset_n), 1);
        chk("short_load_done", 32'(load_done), 0);

        // Reload; the final byte rides on the falling edge and completes the count.
        start_dl();
        chk("reload2_load_error", 32'(load_error), 0);
        chk("reload2_checksum", 32'(checksum), 0);
        for (int i = 0; i < ROM_SIZE - 1; i++) wr_byte(25'(i), 8'(i * 7 + 3));
        ioctl_download = 1'b0;
        wr_byte(25'(ROM_SIZE - 1), 8'h5A);
        in_load = 0;
        chk("edge_byte_load_error", 32'(load_error), 0);
        chk("edge_byte_checksum", 32'(checksum), 32'(exp_sum()));
        wait_run("edge_settle_cycles");
        chk("edge_load_done", 32'(load_done), 1);

        // Out-of-range byte: dropped, error set, checksum untouched.
        start_dl();
        for (int i = 0; i < 'h100; i++) wr_byte(25'(i), 8'(i));
        wr_byte(25'(ROM_SIZE), 8'hAA);
        chk("oor_load_error", 32'(load_error), 1);
        chk("oor_checksum", 32'(checksum), 32'(exp_sum()));

        // Reset at byte 'h100 of a second block; download stays high.
        btnCpuReset = 1'b0;
        in_load     = 0;
        wr_byte(25'h100, 8'h77);
        tick();
        btnCpuReset = 1'b1;
        m_sum       = '0;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) wr_byte(25'(i), 8'h33);
            else            tick();
        end
        chk("abort_core_reset_n", 32'(core_reset_n), 0);
        chk("abort_load_error", 32'(load_error), 0);
        chk("abort_checksum", 32'(checksum), 0);
        chk("abort_dl_wr", 32'(dl_wr), 0);

        // A fresh rising edge starts a new load.
        ioctl_download = 1'b0;
        tick();
        start_dl();
        wr_byte(25'h4000, 8'hC3);
        tick();
        chk("fresh_checksum", 32'(checksum), 32'(exp_sum()));
        ioctl_download = 1'b0;
        tick();
        in_load = 0;
        chk("fresh_load_error", 32'(load_error), 1);
        repeat (3) tick();

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
